// File: rtl/snake_body_engine.sv
// Snake body/motion engine: head steering, segment shift register, growth, collisions, game FSM.
// Define WRAP_AROUND_EN to make the playfield toroidal instead of walls being fatal.
module snake_body_engine #(
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned COORD_W  = 11,
   parameter int unsigned STEP     = 10,
   parameter int unsigned H_MIN    = 0,
   parameter int unsigned H_MAX    = 630,
   parameter int unsigned V_MIN    = 0,
   parameter int unsigned V_MAX    = 470,
   parameter int unsigned START_H  = 320,
   parameter int unsigned START_V  = 240,
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       step_en,
   input  logic                       dir_valid,
   input  logic [1:0]                 dir_in,
   input  logic [COORD_W-1:0]         food_h,
   input  logic [COORD_W-1:0]         food_v,
   output logic [MAX_LEN*COORD_W-1:0] seg_h_flat,
   output logic [MAX_LEN*COORD_W-1:0] seg_v_flat,
   output logic [MAX_LEN-1:0]         seg_active,
   output logic [LEN_W-1:0]           length,
   output logic                       food_eaten,
   output logic                       lose,
   output logic                       win,
   output logic                       running
);

   typedef enum logic [1:0] {StIdle, StRun, StLose, StWin} state_e;
   typedef logic [COORD_W-1:0] coord_t;

   state_e           state_q, state_d;
   coord_t           seg_h_q [MAX_LEN];
   coord_t           seg_h_d [MAX_LEN];
   coord_t           seg_v_q [MAX_LEN];
   coord_t           seg_v_d [MAX_LEN];
   coord_t           init_h  [MAX_LEN];
   coord_t           init_v  [MAX_LEN];
   logic [LEN_W-1:0] length_q, length_d;
   logic [1:0]       cur_dir_q, cur_dir_d;
   logic [1:0]       pend_dir_q, pend_dir_d;
   logic             food_eaten_q, food_eaten_d;

   coord_t           next_h, next_v;
   logic             edge_hit, wall_lose, self_hit, grow;
   int unsigned      hh, hv, lim;

   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         init_h[i] = coord_t'(START_H - i * STEP);
         init_v[i] = coord_t'(START_V);
      end
   end

   // Candidate head position; edge_hit flags a step that would leave the legal range.
   always_comb begin
      hh       = 32'(seg_h_q[0]);
      hv       = 32'(seg_v_q[0]);
      next_h   = seg_h_q[0];
      next_v   = seg_v_q[0];
      edge_hit = 1'b0;
      unique case (pend_dir_q)
         2'b00: begin
            edge_hit = (hh + STEP > H_MAX);
            next_h   = edge_hit ? coord_t'(H_MIN) : coord_t'(hh + STEP);
         end
         2'b01: begin
            edge_hit = (hh < H_MIN + STEP);
            next_h   = edge_hit ? coord_t'(H_MAX) : coord_t'(hh - STEP);
         end
         2'b10: begin
            edge_hit = (hv < V_MIN + STEP);
            next_v   = edge_hit ? coord_t'(V_MAX) : coord_t'(hv - STEP);
         end
         2'b11: begin
            edge_hit = (hv + STEP > V_MAX);
            next_v   = edge_hit ? coord_t'(V_MIN) : coord_t'(hv + STEP);
         end
      endcase
`ifdef WRAP_AROUND_EN
      wall_lose = 1'b0;
`else
      wall_lose = edge_hit;
`endif
      grow     = (next_h == food_h) && (next_v == food_v);
      // The tail vacates its slot on a plain move, but stays put when growing.
      lim      = 32'(length_q) + (grow ? 32'd1 : 32'd0);
      self_hit = 1'b0;
      for (int unsigned j = 0; j < MAX_LEN; j++) begin
         if ((j + 1 < lim) && (seg_h_q[j] == next_h) && (seg_v_q[j] == next_v)) begin
            self_hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      seg_h_d      = seg_h_q;
      seg_v_d      = seg_v_q;
      length_d     = length_q;
      cur_dir_d    = cur_dir_q;
      pend_dir_d   = pend_dir_q;
      food_eaten_d = 1'b0;
      unique case (state_q)
         StIdle, StLose, StWin: begin
            if (start) begin
               state_d    = StRun;
               seg_h_d    = init_h;
               seg_v_d    = init_v;
               length_d   = LEN_W'(INIT_LEN);
               cur_dir_d  = 2'b00;
               pend_dir_d = 2'b00;
            end
         end
         StRun: begin
            if (step_en) begin
               cur_dir_d = pend_dir_q;
               if (wall_lose || self_hit) begin
                  state_d = StLose;
               end else begin
                  for (int unsigned i = 1; i < MAX_LEN; i++) begin
                     seg_h_d[i] = seg_h_q[i-1];
                     seg_v_d[i] = seg_v_q[i-1];
                  end
                  seg_h_d[0] = next_h;
                  seg_v_d[0] = next_v;
                  if (grow) begin
                     length_d     = length_q + 1'b1;
                     food_eaten_d = 1'b1;
                     if (32'(length_q) + 1 == MAX_LEN) state_d = StWin;
                  end
               end
            end
            // Reversal is judged against the direction in force after this cycle.
            if (dir_valid && !is_opposite(dir_in, cur_dir_d)) pend_dir_d = dir_in;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         seg_h_q      <= init_h;
         seg_v_q      <= init_v;
         length_q     <= LEN_W'(INIT_LEN);
         cur_dir_q    <= 2'b00;
         pend_dir_q   <= 2'b00;
         food_eaten_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         seg_h_q      <= seg_h_d;
         seg_v_q      <= seg_v_d;
         length_q     <= length_d;
         cur_dir_q    <= cur_dir_d;
         pend_dir_q   <= pend_dir_d;
         food_eaten_q <= food_eaten_d;
      end
   end

   always_comb begin
      seg_h_flat = '0;
      seg_v_flat = '0;
      seg_active = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         seg_h_flat[i*COORD_W +: COORD_W] = seg_h_q[i];
         seg_v_flat[i*COORD_W +: COORD_W] = seg_v_q[i];
         seg_active[i]                    = (i < 32'(length_q));
      end
   end

   assign length     = length_q;
   assign food_eaten = food_eaten_q;
   assign lose       = (state_q == StLose);
   assign win        = (state_q == StWin);
   assign running    = (state_q == StRun);

endmodule
